// File: rtl/i2s_stereo_tx.sv
`default_nettype none
// ============================================================================
// i2s_stereo_tx : FIFO-buffered I2S DAC transmitter slaved to codec SCLK/LRCLK
// Define I2S_UNDERRUN_CNT_EN to add the saturating underrun_cnt port. Rev 1.0
// ============================================================================
module i2s_stereo_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [2*SAMPLE_W-1:0]       s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        i2s_sclk,
  input  logic                        i2s_lrclk,
  output logic                        i2s_dout,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun
`ifdef I2S_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                 underrun_cnt
`endif
);

  localparam int                 c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL   = FIFO_DEPTH[c_PTR_W:0];
  localparam logic [0:0]         c_S_IDLE = 1'b0;
  localparam logic [0:0]         c_S_RUN  = 1'b1;

  logic [1:0]             r_sclk_sync;
  logic [1:0]             r_lrclk_sync;
  logic                   r_sclk_d;
  logic                   r_lrclk_prev;
  logic                   w_fall;
  logic                   w_lr;
  logic                   w_boundary;
  logic                   w_load_l;
  logic                   w_load_r;

  logic [2*SAMPLE_W-1:0]  r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]     r_wr_ptr;
  logic [c_PTR_W-1:0]     r_rd_ptr;
  logic [c_PTR_W:0]       r_level;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  logic [2*SAMPLE_W-1:0]  w_head;

  logic [0:0]             r_state;
  logic [SLOT_W-1:0]      r_shreg;
  logic [SAMPLE_W-1:0]    r_rhold;
  logic                   r_dout;
  logic                   r_underrun;
  logic                   w_underrun_set;
  logic [SLOT_W-1:0]      w_left_slot;
  logic [SLOT_W-1:0]      w_right_slot;

  // Equal-depth synchronisers keep LRCLK aligned with the detected SCLK fall
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sclk_sync  <= '0;
      r_lrclk_sync <= '0;
      r_sclk_d     <= 1'b0;
      r_lrclk_prev <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[0], i2s_sclk};
      r_lrclk_sync <= {r_lrclk_sync[0], i2s_lrclk};
      r_sclk_d     <= r_sclk_sync[1];
      if (w_fall) begin
        r_lrclk_prev <= r_lrclk_sync[1];
      end
    end
  end

  assign w_fall         = r_sclk_d & ~r_sclk_sync[1];
  assign w_lr           = r_lrclk_sync[1];
  assign w_boundary     = w_fall & (w_lr != r_lrclk_prev);
  assign w_load_l       = w_boundary & ~w_lr;
  assign w_load_r       = w_boundary & w_lr & (r_state == c_S_RUN);

  assign w_empty        = (r_level == '0);
  assign s_ready        = (r_level != c_FULL);
  assign w_push         = s_valid & s_ready;
  assign w_pop          = w_load_l & ~w_empty;
  assign w_underrun_set = w_load_l & w_empty;
  assign w_head         = r_mem[r_rd_ptr];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= s_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_left_slot                          = '0;
    w_left_slot[SLOT_W-1 -: SAMPLE_W]    = w_head[2*SAMPLE_W-1 -: SAMPLE_W];
    w_right_slot                         = '0;
    w_right_slot[SLOT_W-1 -: SAMPLE_W]   = r_rhold;
  end

  // A left-slot start always loads a whole pair (or zeros), so L/R never slip
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= c_S_IDLE;
      r_shreg    <= '0;
      r_rhold    <= '0;
      r_dout     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_underrun_set;
      if (w_load_l) begin
        r_state <= c_S_RUN;
        r_dout  <= 1'b0;
        if (w_empty) begin
          r_shreg <= '0;
          r_rhold <= '0;
        end else begin
          r_shreg <= w_left_slot;
          r_rhold <= w_head[SAMPLE_W-1:0];
        end
      end else if (w_load_r) begin
        r_shreg <= w_right_slot;
        r_dout  <= 1'b0;
      end else if (w_fall && (r_state == c_S_RUN)) begin
        r_dout  <= r_shreg[SLOT_W-1];
        r_shreg <= r_shreg << 1;
      end
    end
  end

  assign i2s_dout   = r_dout;
  assign underrun   = r_underrun;
  assign fifo_level = r_level;

`ifdef I2S_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun_set && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_stereo_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_i2s_stereo_tx : scoreboard bench, expected slot samples queued at frame
// issue and popped by an SCLK-rising-edge monitor. Rev 1.0
// ============================================================================
module tb_i2s_stereo_tx;

  localparam int FIFO_DEPTH = 8;
  localparam int c_HALF     = 163;

  logic        Clk       = 1'b0;
  logic        Reset     = 1'b0;
  logic [31:0] s_data    = '0;
  logic        s_valid   = 1'b0;
  logic        i2s_sclk  = 1'b1;
  logic        i2s_lrclk = 1'b1;
  logic        s_ready;
  logic        i2s_dout;
  logic [3:0]  fifo_level;
  logic        underrun;
`ifdef I2S_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  i2s_stereo_tx #(.SAMPLE_W(16), .SLOT_W(32), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .i2s_sclk     (i2s_sclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_dout     (i2s_dout),
    .fifo_level   (fifo_level),
    .underrun     (underrun)
`ifdef I2S_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #10 Clk = ~Clk;

  int          total        = 0;
  int          bad          = 0;
  logic [31:0] mq[$];
  logic [15:0] exp_q[$];
  int          exp_ur       = 0;
  int          ur_seen      = 0;
  int          ur_since_rst = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) if (underrun === 1'b1) ur_seen++;

  // Bit captured at an SCLK rise belongs to the slot of the previous rise's LRCLK
  logic [63:0] m_acc     = '0;
  int          m_cnt     = 0;
  logic        m_lr_p    = 1'b0;
  logic        m_have    = 1'b0;
  logic        m_started = 1'b0;

  always @(posedge i2s_sclk or posedge Reset) begin
    if (Reset) begin
      m_have    = 1'b0;
      m_started = 1'b0;
      m_acc     = '0;
      m_cnt     = 0;
    end else begin
      m_acc = {m_acc[62:0], i2s_dout};
      m_cnt++;
      if (!m_have) begin
        m_have = 1'b1;
        m_lr_p = i2s_lrclk;
      end else if (i2s_lrclk != m_lr_p) begin
        m_lr_p = i2s_lrclk;
        if (!m_started) begin
          check("prestart_dout_zero", m_acc, 64'd0);
          m_started = 1'b1;
        end else if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_slot: got %0h want no slot", m_acc);
        end else begin
          logic [15:0] s;
          logic [63:0] ev;
          s = exp_q.pop_front();
          if (m_cnt < 16) begin
            total++;
            bad++;
            $display("FAIL slot_len: got %0d want >=16", m_cnt);
          end else begin
            ev = {48'd0, s} << (m_cnt - 16);
            check("slot_data", m_acc, ev);
          end
        end
        m_acc = '0;
        m_cnt = 0;
      end
    end
  end

  task automatic sbit(input logic lr);
    i2s_sclk  = 1'b0;
    i2s_lrclk = lr;
    #(c_HALF);
    i2s_sclk  = 1'b1;
    #(c_HALF);
  endtask

  task automatic lead_in(input int n);
    repeat (n) sbit(1'b1);
  endtask

  task automatic left_start(input bit score);
    logic [31:0] p;
    if (mq.size() != 0) begin
      p = mq.pop_front();
    end else begin
      p = '0;
      exp_ur++;
      ur_since_rst++;
    end
    if (score) begin
      exp_q.push_back(p[31:16]);
      exp_q.push_back(p[15:0]);
    end
    sbit(1'b0);
  endtask

  task automatic rest(input int n);
    repeat (n - 1) sbit(1'b0);
    repeat (n) sbit(1'b1);
  endtask

  task automatic frame(input int n);
    left_start(1'b1);
    rest(n);
  endtask

  task automatic push(input logic [31:0] d);
    @(negedge Clk);
    s_data  = d;
    s_valid = 1'b1;
    check("s_ready_at_push", s_ready, (mq.size() < FIFO_DEPTH));
    if (mq.size() < FIFO_DEPTH) mq.push_back(d);
    @(negedge Clk);
    s_valid = 1'b0;
  endtask

  task automatic check_state(input string tag);
    @(negedge Clk);
    check({tag, "_level"}, fifo_level, mq.size());
    check({tag, "_ready"}, s_ready, (mq.size() < FIFO_DEPTH));
    check({tag, "_underruns"}, ur_seen, exp_ur);
`ifdef I2S_UNDERRUN_CNT_EN
    check({tag, "_underrun_cnt"}, underrun_cnt, ur_since_rst);
`endif
  endtask

  task automatic do_reset();
    mq.delete();
    exp_q.delete();
    ur_since_rst = 0;
    Reset = 1'b1;
    #1;
    check("rst_dout", i2s_dout, 1'b0);
    check("rst_level", fifo_level, 0);
    repeat (3) @(negedge Clk);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ready", s_ready, 1'b1);
`ifdef I2S_UNDERRUN_CNT_EN
    check("rst_underrun_cnt", underrun_cnt, 0);
`endif
    Reset = 1'b0;
  endtask

  task automatic finish_test(input string tag);
    check({tag, "_scoreboard_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: single pair, 32-SCLK slots
    do_reset();
    push({16'hA5C3, 16'h0F0F});
    check_state("t1_pushed");
    lead_in(2);
    frame(32);
    left_start(1'b0);
    check_state("t1_done");
    finish_test("t1");

    // 2: fill to full, reject 9th, pop order and pointer wrap
    do_reset();
    for (int i = 0; i < 9; i++) push({16'h1000 + 16'(i), 16'h2000 + 16'(i)});
    check_state("t2_full");
    lead_in(2);
    left_start(1'b1);
    check_state("t2_one_pop");
    rest(32);
    frame(32);
    push(32'hBEEF_CAFE);
    push(32'h7531_8642);
    check_state("t2_refill");
    frame(32);
    left_start(1'b0);
    check_state("t2_done");
    finish_test("t2");

    // 3: empty FIFO, underrun per frame
    do_reset();
    lead_in(2);
    repeat (3) frame(32);
    check_state("t3_three_frames");
    left_start(1'b0);
    finish_test("t3");

    // 4: LRCLK starts mid right slot, nothing popped before the first fall
    do_reset();
    push({16'h8001, 16'hC3A5});
    lead_in(10);
    check_state("t4_no_early_pop");
    frame(32);
    left_start(1'b0);
    check_state("t4_done");
    finish_test("t4");

    // 5: reset in the middle of a left slot with pairs queued
    do_reset();
    push({16'hFFFF, 16'h1234});
    push({16'h5555, 16'hAAAA});
    push({16'h0001, 16'h8000});
    lead_in(2);
    left_start(1'b0);
    repeat (10) sbit(1'b0);
    do_reset();
    push({16'h4321, 16'hFEDC});
    push({16'h00FF, 16'hFF00});
    lead_in(2);
    frame(32);
    frame(32);
    left_start(1'b0);
    check_state("t5_done");
    finish_test("t5");

    // 6: short 24-SCLK slots
    do_reset();
    push({16'h9ABC, 16'h1357});
    push({16'hF00D, 16'h0C0A});
    lead_in(2);
    frame(24);
    frame(24);
    left_start(1'b0);
    check_state("t6_done");
    finish_test("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
